// File: rtl/multicycle_control.sv
// Multicycle main-control FSM: fetch/decode/execute/memory/writeback sequencing with memory stall.
// Optional retired-instruction counter enabled by defining MULTICYCLE_INSTRET_EN.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       irwrite,
    output logic [1:0] pcsource,
    output logic       aluop1,
    output logic       aluop0,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       regwrite,
    output logic       regdst,
    output logic [3:0] state,
    output logic       illegal
`ifdef MULTICYCLE_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    // state  | meaning
    // FETCH  | read instruction, PC+4 (stalls on mem_ready)
    // DECODE | register read, branch target, opcode dispatch
    // MEMADR | effective address for lw/sw
    // MEMRD  | data read (stalls on mem_ready)
    // MEMWB  | load writeback
    // MEMWR  | data write (stalls on mem_ready)
    // EXEC   | R-type ALU operation
    // RWB    | R-type writeback
    // BRANCH | beq compare and conditional PC write
    // JUMP   | jump target to PC
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        pcsource    = 2'b00;
        aluop1      = 1'b0;
        aluop0      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: illegal = 1'b0;
                    default:                              illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop1  = 1'b1;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop0      = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            default: ;
        endcase
        // Reset cycle must never leak a write enable or strobe to the datapath.
        if (!rst_n) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            iord        = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            memtoreg    = 1'b0;
            irwrite     = 1'b0;
            pcsource    = 2'b00;
            aluop1      = 1'b0;
            aluop0      = 1'b0;
            alusrca     = 1'b0;
            alusrcb     = 2'b00;
            regwrite    = 1'b0;
            regdst      = 1'b0;
            illegal     = 1'b0;
        end
    end

`ifdef MULTICYCLE_INSTRET_EN
    logic retire;

    assign retire = (state_q == S_MEMWB) || (state_q == S_RWB) ||
                    (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                    ((state_q == S_MEMWR) && mem_ready);

    always_ff @(posedge clk) begin
        if (!rst_n)      instret <= 32'd0;
        else if (retire) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; instret checks active when MULTICYCLE_INSTRET_EN is defined.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
    logic [1:0] pcsource;
    logic       aluop1, aluop0, alusrca;
    logic [1:0] alusrcb;
    logic       regwrite, regdst, illegal;
    logic [3:0] state;
`ifdef MULTICYCLE_INSTRET_EN
    logic [31:0] instret;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .irwrite(irwrite), .pcsource(pcsource), .aluop1(aluop1), .aluop0(aluop0),
        .alusrca(alusrca), .alusrcb(alusrcb), .regwrite(regwrite), .regdst(regdst),
        .state(state), .illegal(illegal)
`ifdef MULTICYCLE_INSTRET_EN
        , .instret(instret)
`endif
    );

    // {pcwrite,pcwritecond,iord,memread,memwrite,memtoreg,irwrite,pcsource,
    //  aluop1,aluop0,alusrca,alusrcb,regwrite,regdst,illegal}
    logic [16:0] outs;
    assign outs = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                   pcsource, aluop1, aluop0, alusrca, alusrcb, regwrite, regdst, illegal};

    localparam logic [16:0] O_ZERO   = 17'b0_0_0_0_0_0_0_00_0_0_0_00_0_0_0;
    localparam logic [16:0] O_FETCH  = 17'b1_0_0_1_0_0_1_00_0_0_0_01_0_0_0;
    localparam logic [16:0] O_FSTALL = 17'b0_0_0_1_0_0_0_00_0_0_0_01_0_0_0;
    localparam logic [16:0] O_DECODE = 17'b0_0_0_0_0_0_0_00_0_0_0_11_0_0_0;
    localparam logic [16:0] O_DECILL = 17'b0_0_0_0_0_0_0_00_0_0_0_11_0_0_1;
    localparam logic [16:0] O_MEMADR = 17'b0_0_0_0_0_0_0_00_0_0_1_10_0_0_0;
    localparam logic [16:0] O_MEMRD  = 17'b0_0_1_1_0_0_0_00_0_0_0_00_0_0_0;
    localparam logic [16:0] O_MEMWB  = 17'b0_0_0_0_0_1_0_00_0_0_0_00_1_0_0;
    localparam logic [16:0] O_MEMWR  = 17'b0_0_1_0_1_0_0_00_0_0_0_00_0_0_0;
    localparam logic [16:0] O_EXEC   = 17'b0_0_0_0_0_0_0_00_1_0_1_00_0_0_0;
    localparam logic [16:0] O_RWB    = 17'b0_0_0_0_0_0_0_00_0_0_0_00_1_1_0;
    localparam logic [16:0] O_BRANCH = 17'b0_1_0_0_0_0_0_01_0_1_1_00_0_0_0;
    localparam logic [16:0] O_JUMP   = 17'b1_0_0_0_0_0_0_10_0_0_0_00_0_0_0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge with inputs set; checks the cycle, then advances one edge.
    task automatic cyc(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_outs);
        #2;
        check({tag, "_state"}, {28'd0, state}, {28'd0, exp_state});
        check({tag, "_outs"}, {15'd0, outs}, {15'd0, exp_outs});
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input string tag, input logic [31:0] exp);
`ifdef MULTICYCLE_INSTRET_EN
        #2;
        check({tag, "_instret"}, instret, exp);
`else
        if (exp === 32'hxxxx_xxxx) $display("unused %s", tag);
`endif
    endtask

    task automatic rtype(input string tag);
        opcode = 6'b000000;
        cyc({tag, "_f"}, 4'd0, O_FETCH);
        cyc({tag, "_d"}, 4'd1, O_DECODE);
        cyc({tag, "_x"}, 4'd6, O_EXEC);
        cyc({tag, "_w"}, 4'd7, O_RWB);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'b000000;
        @(posedge clk);
        #1;
        cyc("reset", 4'd0, O_ZERO);
        ret("reset", 32'd0);

        rst_n = 1'b1;
        rtype("rtype");
        ret("rtype", 32'd1);

        // lw with one FETCH stall and two MEMRD stall cycles
        opcode = 6'b100011;
        mem_ready = 1'b0;
        cyc("lw_fstall", 4'd0, O_FSTALL);
        mem_ready = 1'b1;
        cyc("lw_f", 4'd0, O_FETCH);
        cyc("lw_d", 4'd1, O_DECODE);
        cyc("lw_a", 4'd2, O_MEMADR);
        mem_ready = 1'b0;
        cyc("lw_rd0", 4'd3, O_MEMRD);
        cyc("lw_rd1", 4'd3, O_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_rd2", 4'd3, O_MEMRD);
        cyc("lw_wb", 4'd4, O_MEMWB);
        ret("lw", 32'd2);

        // sw with one MEMWR stall
        opcode = 6'b101011;
        cyc("sw_f", 4'd0, O_FETCH);
        cyc("sw_d", 4'd1, O_DECODE);
        cyc("sw_a", 4'd2, O_MEMADR);
        mem_ready = 1'b0;
        cyc("sw_wr0", 4'd5, O_MEMWR);
        ret("sw_stall", 32'd2);
        mem_ready = 1'b1;
        cyc("sw_wr1", 4'd5, O_MEMWR);
        ret("sw", 32'd3);

        opcode = 6'b000100;
        cyc("beq_f", 4'd0, O_FETCH);
        cyc("beq_d", 4'd1, O_DECODE);
        cyc("beq_b", 4'd8, O_BRANCH);
        ret("beq", 32'd4);

        opcode = 6'b000010;
        cyc("j_f", 4'd0, O_FETCH);
        cyc("j_d", 4'd1, O_DECODE);
        cyc("j_j", 4'd9, O_JUMP);
        ret("j", 32'd5);

        opcode = 6'b111111;
        cyc("ill_f", 4'd0, O_FETCH);
        cyc("ill_d", 4'd1, O_DECILL);
        cyc("ill_back", 4'd0, O_FETCH);
        ret("ill", 32'd5);
        // that FETCH cycle advanced to DECODE; finish with a legal op
        opcode = 6'b000010;
        cyc("j2_d", 4'd1, O_DECODE);
        cyc("j2_j", 4'd9, O_JUMP);
        ret("j2", 32'd6);

        // reset while in MEMWR aborts the store
        opcode = 6'b101011;
        cyc("swr_f", 4'd0, O_FETCH);
        cyc("swr_d", 4'd1, O_DECODE);
        cyc("swr_a", 4'd2, O_MEMADR);
        rst_n = 1'b0;
        cyc("swr_rst", 4'd5, O_ZERO);
        ret("swr_rst", 32'd0);
        cyc("swr_rst2", 4'd0, O_ZERO);
        rst_n = 1'b1;

        rtype("r1");
        rtype("r2");
        rtype("r3");
        ret("r3", 32'd3);
        cyc("final", 4'd0, O_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
